// File: rtl/cpu_isa_pkg.sv
// MIPS opcode/funct encodings shared with the control decoder, plus the
// boot-loader state and error encodings.
package cpu_isa_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    LD_IDLE, LD_LEN_HI, LD_LEN_LO, LD_DATA, LD_CSUM, LD_DONE, LD_ERROR
  } ld_state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CSUM = 2'd2
  } ld_err_e;

endpackage

// File: rtl/imem_insn_check.sv
// Combinational check: is this word an instruction the control decoder handles?
module imem_insn_check
  import cpu_isa_pkg::*;
(
  input  logic [31:0] word_i,
  output logic        legal_o
);

  always_comb begin
    legal_o = 1'b0;
    case (word_i[31:26])
      OP_RTYPE: begin
        case (word_i[5:0])
          F_SLL, F_SRL, F_SRA, F_JR,
          F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: legal_o = 1'b1;
          default:       legal_o = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_LUI, OP_SPECIAL2, OP_LW, OP_SW: legal_o = 1'b1;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream boot loader: LEN_HI LEN_LO, 4*N big-endian payload bytes,
// XOR checksum. Writes instruction memory and holds the CPU until verified.
module imem_loader
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   illegal_cnt
);

  localparam logic [16:0]         MAX_WORDS = 17'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ILL_MAX   = '1;
  localparam logic [ADDR_WIDTH:0] ILL_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  ld_state_e             state_q, state_d;
  ld_err_e               ecode_q, ecode_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           widx_q, widx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH:0]   ill_q, ill_d;

  logic        accept, legal;
  logic [31:0] word_full;
  logic [16:0] len_full;

  assign in_ready  = (state_q == LD_LEN_HI) || (state_q == LD_LEN_LO) ||
                     (state_q == LD_DATA)   || (state_q == LD_CSUM);
  assign accept    = in_valid && in_ready;
  assign word_full = {word_q, in_data};
  assign len_full  = {1'b0, len_q[15:8], in_data};

  imem_insn_check u_check (
    .word_i  (word_full),
    .legal_o (legal)
  );

  always_comb begin
    state_d = state_q;
    ecode_d = ecode_q;
    len_d   = len_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    ill_d   = ill_q;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (start) begin
          state_d = LD_LEN_HI;
          ecode_d = ERR_NONE;
          len_d   = '0;
          widx_d  = '0;
          bcnt_d  = '0;
          csum_d  = '0;
          ill_d   = '0;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LD_LEN_HI: if (accept) begin
        len_d[15:8] = in_data;
        state_d     = LD_LEN_LO;
      end
      LD_LEN_LO: if (accept) begin
        len_d[7:0] = in_data;
        if (len_full > MAX_WORDS) begin
          state_d = LD_ERROR;
          err_d   = 1'b1;
          ecode_d = ERR_LEN;
        end else if (len_full == 17'd0) begin
          state_d = LD_CSUM;
        end else begin
          state_d = LD_DATA;
        end
      end
      LD_DATA: if (accept) begin
        csum_d = csum_q ^ in_data;
        word_d = {word_q[15:0], in_data};
        bcnt_d = bcnt_q + 2'd1;
        // 4th byte: word is complete this cycle, written on the next one
        if (bcnt_q == 2'd3) begin
          we_d    = 1'b1;
          wdata_d = word_full;
          addr_d  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(widx_q);
          widx_d  = widx_q + 16'd1;
          if (!legal && ill_q != ILL_MAX) ill_d = ill_q + ILL_ONE;
          if ((widx_q + 16'd1) == len_q) state_d = LD_CSUM;
        end
      end
      LD_CSUM: if (accept) begin
        if (in_data == csum_q) begin
          state_d = LD_DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else begin
          state_d = LD_ERROR;
          err_d   = 1'b1;
          ecode_d = ERR_CSUM;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LD_IDLE;
      ecode_q <= ERR_NONE;
      len_q   <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= ADDR_WIDTH'(BASE_ADDR);
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ill_q   <= '0;
    end else begin
      state_q <= state_d;
      ecode_q <= ecode_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ill_q   <= ill_d;
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_hold    = hold_q;
  assign done        = done_q;
  assign error       = err_q;
  assign err_code    = ecode_q;
  assign illegal_cnt = ill_q;

endmodule

// File: tb/tb_imem_loader.sv
// Frame-level bench for imem_loader: table of frames plus hand-written corner
// sequences; a write scoreboard checks every imem write address/data.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready;
  logic [7:0]  in_data;
  logic        imem_we, cpu_hold, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0]  err_code;
  logic [8:0]  illegal_cnt;

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .err_code(err_code), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    string             name;
    int                n;
    logic [3:0][31:0]  w;
    bit                bad;
    bit                exp_done;
    logic [1:0]        exp_code;
    int                exp_ill;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  wr_t  sbq[$];
  wr_t  mon_e;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every write the DUT makes must match the next expected one.
  always @(negedge clk) begin
    if (reset === 1'b1 && imem_we === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = sbq.pop_front();
        chk("wr_addr", imem_addr, mon_e.a);
        chk("wr_data", imem_wdata, mon_e.d);
      end
    end
  end

  function automatic vec_t mk(input string nm, input int n, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                              input bit bad, input int ill);
    vec_t v;
    v.name = nm; v.n = n; v.w = {w3, w2, w1, w0}; v.bad = bad;
    v.exp_done = !bad; v.exp_code = bad ? 2'd2 : 2'd0; v.exp_ill = ill;
    return v;
  endfunction

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
    chk("in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("start_hold", cpu_hold, 1'b1);
    chk("start_flags", {done, error, err_code, illegal_cnt}, '0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_ready"}, in_ready, 1'b0);
    chk({nm, "_we"}, imem_we, 1'b0);
    chk({nm, "_addr"}, imem_addr, 8'h00);
    chk({nm, "_wdata"}, imem_wdata, 32'h0);
    chk({nm, "_hold"}, cpu_hold, 1'b1);
    chk({nm, "_done_err"}, {done, error, err_code}, 4'b0);
    chk({nm, "_ill"}, illegal_cnt, 9'd0);
  endtask

  // Sends a whole frame; mid_start >= 0 pulses start before that payload byte.
  task automatic run_frame(input string nm, input logic [31:0] ws[$], input bit bad,
                           input bit gaps, input int mid_start, input bit exp_done,
                           input logic [1:0] exp_code, input int exp_ill);
    logic [15:0] lenv;
    logic [7:0]  cs, b;
    int          k;
    lenv = 16'(ws.size());
    cs   = 8'h00;
    k    = 0;
    pulse_start();
    send(lenv[15:8], gaps);
    send(lenv[7:0], gaps);
    for (int i = 0; i < ws.size(); i++) begin
      for (int j = 3; j >= 0; j--) begin
        b  = ws[i][8*j +: 8];
        cs = cs ^ b;
        if (k == mid_start) begin
          start = 1'b1; in_valid = 1'b0;
          @(posedge clk); @(negedge clk);
          start = 1'b0;
        end
        if (j == 0) sbq.push_back('{a: 8'(i), d: ws[i]});
        send(b, gaps);
        if (j == 0) chk({nm, "_we_latency"}, imem_we, 1'b1);
        k++;
      end
    end
    send(bad ? (cs ^ 8'h01) : cs, gaps);
    chk({nm, "_done"}, done, exp_done);
    chk({nm, "_error"}, error, !exp_done);
    chk({nm, "_err_code"}, err_code, exp_code);
    chk({nm, "_hold"}, cpu_hold, !exp_done);
    chk({nm, "_ill"}, illegal_cnt, 9'(exp_ill));
    chk({nm, "_ready_off"}, in_ready, 1'b0);
    chk({nm, "_all_written"}, sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    logic [31:0] ws[$];
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    tbl[0] = mk("normal",   2, 32'h20080005, 32'h00000000, 32'h0, 32'h0, 1'b0, 0);
    tbl[1] = mk("bad_csum", 2, 32'h20080005, 32'h00000000, 32'h0, 32'h0, 1'b1, 0);
    tbl[2] = mk("zero_len", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    tbl[3] = mk("illegal",  1, 32'hFC000000, 32'h0, 32'h0, 32'h0, 1'b0, 1);
    tbl[4] = mk("mixed3",   3, 32'h00851020, 32'h8C430004, 32'h0000000C, 32'h0, 1'b0, 1);
    tbl[5] = mk("special2", 2, 32'h7C000000, 32'h70000002, 32'h0, 32'h0, 1'b0, 1);
    tbl[6] = mk("four_bad", 4, 32'h0800000A, 32'h3C01FFFF, 32'h0000002C, 32'h18000000, 1'b1, 2);
    tbl[7] = mk("rtype",    4, 32'h00000008, 32'h00000027, 32'h00000028, 32'h0000002B, 1'b0, 1);

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    foreach (tbl[t]) begin
      ws.delete();
      for (int i = 0; i < tbl[t].n; i++) ws.push_back(tbl[t].w[i]);
      run_frame(tbl[t].name, ws, tbl[t].bad, t[0], -1,
                tbl[t].exp_done, tbl[t].exp_code, tbl[t].exp_ill);
    end

    // Largest legal image fills every address.
    ws.delete();
    for (int i = 0; i < 256; i++) ws.push_back({8'h20, 8'h08, 8'h00, 8'(i)});
    run_frame("full256", ws, 1'b0, 1'b0, -1, 1'b1, 2'd0, 0);

    // One word too many: rejected on LEN_LO.
    pulse_start();
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    chk("ovf_error", error, 1'b1);
    chk("ovf_code", err_code, 2'd1);
    chk("ovf_ready", in_ready, 1'b0);
    chk("ovf_done_hold", {done, cpu_hold}, 2'b01);
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    in_valid = 1'b0;
    chk("ovf_sticky", {error, err_code}, 3'b101);

    // start during DATA is ignored.
    ws.delete();
    ws.push_back(32'h20080005); ws.push_back(32'h00000000);
    run_frame("mid_start", ws, 1'b0, 1'b0, 2, 1'b1, 2'd0, 0);

    // Reset mid-load, then a clean restart.
    pulse_start();
    send(8'h00, 1'b1); send(8'h01, 1'b1); send(8'h20, 1'b1); send(8'h08, 1'b1);
    idle_cycle(); idle_cycle();
    reset = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("after_reset");
    run_frame("restart", ws, 1'b1 ^ 1'b1, 1'b1, -1, 1'b1, 2'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
